radix4_booth_mult_param: RTL
============================

Name: radix4_booth_mult_param

Overview:
Parametrised sequential radix-4 Booth multiplier with valid/ready handshakes on both sides. It adds runtime signed/unsigned mode select and a clock-enable stall to the fixed 32-bit registered multiplier. It retires two multiplier bits per active cycle. It sits between operand-producing datapath logic and a result consumer that may apply backpressure.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4; product is 2*WIDTH bits
ITER (localparam), WIDTH/2+1, Booth iterations per operation

Ports:
clk  in  1  rising-edge clock; the block's only clock
reset  in  1  synchronous, active-low reset; sampled on clk rising edge
en  in  1  iteration enable; 0 freezes the RUN state and the iteration counter
in_valid  in  1  operand request
in_ready  out  1  block can accept operands (1 only in IDLE)
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
signed_mode  in  1  1: a, b are two's complement; 0: unsigned; sampled with operands
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
product  out  2*WIDTH  result; meaningful while out_valid=1
busy  out  1  1 in RUN or DONE

Behaviour:
- Reset: reset=0 at an edge forces IDLE, out_valid=0, product=0, busy=0, counter=0; in_ready=1 from the first edge with reset=1. Reset applies from any state, including mid-RUN, and aborts the operation with no output.
- FSM IDLE -> RUN: on an edge with in_valid & in_ready. Latches a, b, signed_mode. The multiplicand is extended to WIDTH+2 bits (sign-extended if signed_mode=1, zero-extended otherwise). The multiplier is extended the same way to WIDTH+2 bits, with an implicit 0 appended below the LSB.
- RUN: each edge with en=1 performs one iteration.
  - Recode the 3-bit window into a digit in {-2,-1,0,+1,+2}.
  - Add the selected multiple of the multiplicand into the upper accumulator.
  - Arithmetic-shift the {accumulator, multiplier} register right by 2.
  - Increment the counter.
  - With en=0: no state, counter or register change.
- RUN -> DONE: on the edge completing iteration ITER. That same edge loads the low 2*WIDTH bits into product and sets out_valid=1.
- Latency: with en held 1, out_valid rises exactly ITER edges after the accept edge (17 for WIDTH=32). Each en=0 cycle during RUN adds exactly one cycle.
- DONE: product and out_valid are held stable until an edge with out_ready=1. That edge returns the FSM to IDLE and clears out_valid; product keeps its value. en has no effect in DONE or IDLE.
- No overlap: in_ready=0 in RUN and DONE. in_valid in those states is ignored, not queued. Operand changes after the accept edge have no effect.
- Arithmetic: the accumulator is WIDTH+2 bits with two's-complement wrap inside. The final product is exact for all operand pairs in both modes, including signed -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2) and unsigned (2^WIDTH-1)^2.
- Simultaneous events:
  - reset=0 overrides everything.
  - out_ready=1 in the cycle DONE is entered has no effect. The handshake is evaluated only while out_valid=1 is already visible.

Decomposition:
- Package radix4_booth_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the Booth digit encoding constants (neg, one, two flags);
  - a function returning ITER from WIDTH.
- One combinational sub-module, radix4_booth_recoder, maps a 3-bit window plus the extended multiplicand to a WIDTH+2-bit signed partial product. It is instantiated once.

Test Plan:
1. WIDTH=32, signed, a=5, b=-7, en=1, out_ready=1 -> out_valid 17 cycles after accept; product=-35 (0xFFFFFFFFFFFFFFDD); in_ready=1 on the next cycle.
2. WIDTH=32, a=0xFFFFFFFF, b=2:
   - unsigned -> product=0x00000001FFFFFFFE;
   - signed -> product=0xFFFFFFFFFFFFFFFE.
3. WIDTH=32, signed extremes:
   - 2147483647*3 -> 6442450941;
   - -2^31*-2^31 -> 0x4000000000000000;
   - -547623*2 -> -1095246.
4. Stalls:
   - en=0 for 5 cycles mid-RUN -> out_valid delayed exactly 5 cycles, product correct.
   - out_ready=0 for 3 cycles after out_valid -> product stable, in_ready=0, and a new in_valid is ignored.
5. reset=0 for one edge after 8 iterations -> the next cycle shows IDLE, out_valid=0, product=0, busy=0; the next operation 4*6 returns 24.
6. WIDTH=8, exhaustive over all 65536 operand pairs in both modes against a behavioural model -> all match; latency 5 cycles each.

Source files
------------

// File: rtl/radix4_booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package radix4_booth_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    // A Booth digit is neg * (one ? 1 : two ? 2 : 0).
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    localparam booth_digit_t DigZero = 3'b000;
    localparam booth_digit_t DigPos1 = 3'b010;
    localparam booth_digit_t DigPos2 = 3'b001;
    localparam booth_digit_t DigNeg1 = 3'b110;
    localparam booth_digit_t DigNeg2 = 3'b101;

    function automatic booth_digit_t booth_decode(input logic [2:0] window);
        booth_digit_t dig;
        unique case (window)
            3'b000, 3'b111: dig = DigZero;
            3'b001, 3'b010: dig = DigPos1;
            3'b011:         dig = DigPos2;
            3'b100:         dig = DigNeg2;
            default:        dig = DigNeg1;
        endcase
        return dig;
    endfunction

    function automatic int unsigned iter_count(input int unsigned width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/radix4_booth_recoder.sv
// Maps a 3-bit Booth window and the extended multiplicand to a signed partial product.
module radix4_booth_recoder
    import radix4_booth_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       window,
    input  logic [WIDTH+1:0] mcand,
    output logic [WIDTH+1:0] pp
);

    booth_digit_t     dig;
    logic [WIDTH+1:0] mag;

    // 2*mcand always fits: the multiplicand carries two extension bits.
    always_comb begin
        dig = booth_decode(window);
        mag = '0;
        if (dig.two) begin
            mag = {mcand[WIDTH:0], 1'b0};
        end else if (dig.one) begin
            mag = mcand;
        end
        pp = dig.neg ? -mag : mag;
    end

endmodule

// File: rtl/radix4_booth_mult_param.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per enabled cycle,
// valid/ready on both sides and runtime signed/unsigned select.
module radix4_booth_mult_param
    import radix4_booth_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned ITER = iter_count(WIDTH);
    localparam int unsigned CW   = $clog2(ITER + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] mcand;
    logic [WIDTH+2:0] mult;
    logic [WIDTH+1:0] pp;
    logic [WIDTH+2:0] sum;
    logic [WIDTH+1:0] acc_nxt;
    logic [WIDTH+2:0] mult_nxt;

    radix4_booth_recoder #(
        .WIDTH(WIDTH)
    ) u_recoder (
        .window(mult[2:0]),
        .mcand (mcand),
        .pp    (pp)
    );

    // One guard bit on the add keeps the shifted accumulator exact.
    always_comb begin
        sum      = {acc[WIDTH+1], acc} + {pp[WIDTH+1], pp};
        acc_nxt  = {sum[WIDTH+2], sum[WIDTH+2:2]};
        mult_nxt = {sum[1:0], mult[WIDTH+2:2]};
    end

    assign in_ready = (state == StIdle);
    assign busy     = (state != StIdle);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= StIdle;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mult      <= '0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        mcand <= {{2{signed_mode & a[WIDTH-1]}}, a};
                        mult  <= {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (en) begin
                        acc  <= acc_nxt;
                        mult <= mult_nxt;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(ITER - 1)) begin
                            state     <= StDone;
                            out_valid <= 1'b1;
                            product   <= {acc_nxt[WIDTH-3:0], mult_nxt[WIDTH+2:1]};
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
